// File: rtl/lsu_pkg.sv
// Shared constants and types for the LSU data-memory initiator.
package lsu_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = 2;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned WORD_W = LANES * BYTE_W;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

   // Illegal encoding or misaligned half/word: the op completes without a bus request.
   function automatic logic op_error(input logic load, input logic [2:0] f3,
                                     input logic [LANE_W-1:0] lane);
      logic legal;
      if (load) legal = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      else      legal = f3 inside {F3_SB, F3_SH, F3_SW};
      return !legal || (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != '0);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data shift and strobes, load lane select and extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]        st_funct3,
   input  logic [LANE_W-1:0] st_lane,
   input  logic [WORD_W-1:0] st_wdata,
   output logic [WORD_W-1:0] st_wdata_sh,
   output logic [LANES-1:0]  st_wstrb,
   input  logic [2:0]        ld_funct3,
   input  logic [LANE_W-1:0] ld_lane,
   input  logic [WORD_W-1:0] ld_rdata,
   output logic [WORD_W-1:0] ld_data
);

   logic [BYTE_W-1:0] ld_byte;
   logic [HALF_W-1:0] ld_half;

   assign ld_byte = ld_rdata[{ld_lane, 3'b000} +: BYTE_W];
   assign ld_half = ld_rdata[{ld_lane[1], 4'b0000} +: HALF_W];

   always_comb begin
      st_wdata_sh = '0;
      st_wstrb    = '0;
      case (st_funct3)
         F3_SB: begin
            st_wdata_sh = WORD_W'(st_wdata[BYTE_W-1:0]) << {st_lane, 3'b000};
            st_wstrb    = LANES'(1) << st_lane;
         end
         F3_SH: begin
            st_wdata_sh = WORD_W'(st_wdata[HALF_W-1:0]) << {st_lane, 3'b000};
            st_wstrb    = LANES'(3) << st_lane;
         end
         F3_SW: begin
            st_wdata_sh = st_wdata;
            st_wstrb    = '1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_data = '0;
      case (ld_funct3)
         F3_LB:   ld_data = {{(WORD_W-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
         F3_LH:   ld_data = {{(WORD_W-HALF_W){ld_half[HALF_W-1]}}, ld_half};
         F3_LW:   ld_data = ld_rdata;
         F3_LBU:  ld_data = WORD_W'(ld_byte);
         F3_LHU:  ld_data = WORD_W'(ld_half);
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: EA calc, valid/ready word request, load extend.
// Optional watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   input  logic              op_load,
   input  logic [2:0]        op_funct3,
   input  logic [ADDR_W-1:0] op_base,
   input  logic [ADDR_W-1:0] op_offset,
   input  logic [DATA_W-1:0] op_wdata,
   output logic              stall,
   output logic              op_done,
   output logic [DATA_W-1:0] load_data,
   output logic              misalign_err,
   output logic              bus_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [LANES-1:0]  mem_req_wstrb,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_rdata
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [LANES-1:0]  wstrb;
   } mem_req_t;

   state_e            state_q, state_d;
   mem_req_t          req_q, req_d;
   logic              req_valid_q, req_valid_d;
   logic [2:0]        ld_f3_q, ld_f3_d;
   logic [LANE_W-1:0] ld_lane_q, ld_lane_d;
   logic [DATA_W-1:0] load_data_q, load_data_d;
   logic              op_done_q, op_done_d;
   logic              misalign_q, misalign_d;
   logic [ADDR_W-1:0] ea;
   logic [DATA_W-1:0] st_wdata_sh, ld_data;
   logic [LANES-1:0]  st_wstrb;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;
   logic             expired;
   // Compare one early so op_done lands exactly TIMEOUT_CYCLES after accept.
   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));
   assign bus_err = bus_err_q;
`else
   assign bus_err = 1'b0;
`endif

   assign ea = op_base + op_offset;

   lsu_lane_align u_lane_align (
      .st_funct3   (op_funct3),
      .st_lane     (ea[LANE_W-1:0]),
      .st_wdata    (op_wdata),
      .st_wdata_sh (st_wdata_sh),
      .st_wstrb    (st_wstrb),
      .ld_funct3   (ld_f3_q),
      .ld_lane     (ld_lane_q),
      .ld_rdata    (mem_rsp_rdata),
      .ld_data     (ld_data)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      req_valid_d = 1'b0;
      ld_f3_d     = ld_f3_q;
      ld_lane_d   = ld_lane_q;
      load_data_d = load_data_q;
      op_done_d   = 1'b0;
      misalign_d  = 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
      bus_err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               req_d.we    = !op_load;
               req_d.addr  = {ea[ADDR_W-1:LANE_W], LANE_W'(0)};
               req_d.wdata = op_load ? '0 : st_wdata_sh;
               req_d.wstrb = op_load ? '0 : st_wstrb;
               ld_f3_d     = op_funct3;
               ld_lane_d   = ea[LANE_W-1:0];
`ifdef LSU_TIMEOUT_EN
               cnt_d       = '0;
`endif
               if (op_error(op_load, op_funct3, ea[LANE_W-1:0])) begin
                  state_d    = DONE;
                  op_done_d  = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  state_d     = REQ;
                  req_valid_d = 1'b1;
               end
            end
         end
         REQ: begin
`ifdef LSU_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (mem_req_ready) begin
               if (req_q.we) begin
                  state_d   = DONE;
                  op_done_d = 1'b1;
               end else begin
                  state_d = WAIT_RSP;
               end
`ifdef LSU_TIMEOUT_EN
            end else if (expired) begin
               state_d   = DONE;
               op_done_d = 1'b1;
               bus_err_d = 1'b1;
`endif
            end else begin
               req_valid_d = 1'b1;
            end
         end
         WAIT_RSP: begin
`ifdef LSU_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (mem_rsp_valid) begin
               load_data_d = ld_data;
               state_d     = DONE;
               op_done_d   = 1'b1;
`ifdef LSU_TIMEOUT_EN
            end else if (expired) begin
               state_d   = DONE;
               op_done_d = 1'b1;
               bus_err_d = 1'b1;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= '0;
         req_valid_q <= 1'b0;
         ld_f3_q     <= '0;
         ld_lane_q   <= '0;
         load_data_q <= '0;
         op_done_q   <= 1'b0;
         misalign_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= '0;
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         req_valid_q <= req_valid_d;
         ld_f3_q     <= ld_f3_d;
         ld_lane_q   <= ld_lane_d;
         load_data_q <= load_data_d;
         op_done_q   <= op_done_d;
         misalign_q  <= misalign_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= cnt_d;
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   // Combinational so the pipeline freezes in the same cycle an op is presented.
   assign stall = (state_q == IDLE && op_valid) || state_q == REQ || state_q == WAIT_RSP;

   assign op_done       = op_done_q;
   assign misalign_err  = misalign_q;
   assign load_data     = load_data_q;
   assign mem_req_valid = req_valid_q;
   assign mem_req_we    = req_q.we;
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wdata = req_q.wdata;
   assign mem_req_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed scoreboard bench for lsu_mem_initiator; timeout case runs with LSU_TIMEOUT_EN.
module tb_lsu_mem_initiator;

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned TO = 8;
`else
   localparam int unsigned TO = 64;
`endif

   logic        clk, rst_n;
   logic        op_valid, op_load;
   logic [2:0]  op_funct3;
   logic [31:0] op_base, op_offset, op_wdata;
   logic        stall, op_done, misalign_err, bus_err;
   logic [31:0] load_data;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   typedef struct {
      logic        load;
      logic        err;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic [31:0] ld;
      int          hs;
      int          rsp_cyc;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   logic [31:0] last_ld;

   lsu_mem_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_load(op_load),
      .op_funct3(op_funct3), .op_base(op_base), .op_offset(op_offset), .op_wdata(op_wdata),
      .stall(stall), .op_done(op_done), .load_data(load_data),
      .misalign_err(misalign_err), .bus_err(bus_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model built byte by byte from the RV32I access rules.
   function automatic exp_t model(input logic load, input logic [2:0] f3,
                                  input logic [31:0] base, input logic [31:0] off,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int rdy_dly, input int rsp_dly, input logic [31:0] prev);
      exp_t        e;
      logic [31:0] ea, v;
      int          sz, lane;
      logic        legal;
      ea    = base + off;
      lane  = int'(ea[1:0]);
      sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = load ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) : (f3 <= 3'd2);
      e.load  = load;
      e.err   = !legal || (lane % sz != 0);
      e.addr  = ea & 32'hFFFF_FFFC;
      e.wdata = '0;
      e.wstrb = '0;
      e.rdata = rdata;
      v       = '0;
      if (!e.err) begin
         for (int i = 0; i < sz; i++) begin
            if (!load) begin
               e.wstrb[lane+i]            = 1'b1;
               e.wdata[8*(lane+i) +: 8]   = wdata[8*i +: 8];
            end
            v[8*i +: 8] = rdata[8*(lane+i) +: 8];
         end
      end
      if (load && !f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      e.ld      = (load && !e.err) ? v : prev;
      e.hs      = 1 + rdy_dly;
      e.rsp_cyc = e.hs + rsp_dly;
      e.lat     = e.err ? 1 : (load ? e.rsp_cyc + 1 : e.hs + 1);
      return e;
   endfunction

   task automatic run_op(input logic load, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
      exp_t e;
      bit   done;
      done = 1'b0;
      e = model(load, f3, base, off, wdata, rdata, rdy_dly, rsp_dly, last_ld);
      sb.push_back(e);
      @(negedge clk);
      op_valid = 1'b1; op_load = load; op_funct3 = f3;
      op_base = base; op_offset = off; op_wdata = wdata;
      #1 chk("stall_accept", 32'(stall), 32'(1'b1));
      @(posedge clk);
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge clk);
         chk("op_done", 32'(op_done), 32'(k == sb[0].lat));
         chk("stall", 32'(stall), 32'(k < sb[0].lat));
         chk("req_valid", 32'(mem_req_valid), 32'(!sb[0].err && k <= sb[0].hs));
         if (mem_req_valid) begin
            chk("req_addr", mem_req_addr, sb[0].addr);
            chk("req_wdata", mem_req_wdata, sb[0].wdata);
            chk("req_wstrb", 32'(mem_req_wstrb), 32'(sb[0].wstrb));
            chk("req_we", 32'(mem_req_we), 32'(!sb[0].load));
         end
         if (op_done) begin
            chk("misalign_err", 32'(misalign_err), 32'(sb[0].err));
            chk("bus_err", 32'(bus_err), 32'(1'b0));
            chk("load_data", load_data, sb[0].ld);
            last_ld = sb[0].ld;
            void'(sb.pop_front());
            done     = 1'b1;
            op_valid = 1'b0;
         end
         mem_req_ready = !e.err && k == e.hs;
         mem_rsp_valid = e.load && !e.err && k == e.rsp_cyc;
         mem_rsp_rdata = mem_rsp_valid ? e.rdata : $urandom;
      end
      chk("done_seen", 32'(done), 32'(1'b1));
      op_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_funct3 = '0;
      op_base = '0; op_offset = '0; op_wdata = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; last_ld = '0;
      repeat (2) @(negedge clk);
      chk("rst_stall", 32'(stall), 32'(1'b0));
      chk("rst_op_done", 32'(op_done), 32'(1'b0));
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'(1'b0));
      chk("rst_req_addr", mem_req_addr, 32'h0);
      rst_n = 1'b1;

      run_op(1'b0, 3'b000, 32'h10, 32'd3, 32'h0000_00AB, 32'h0, 0, 1);        // SB lane 3
      run_op(1'b1, 3'b000, 32'h10, 32'd3, 32'h0, 32'hAB00_0000, 0, 1);         // LB
      run_op(1'b1, 3'b100, 32'h10, 32'd3, 32'h0, 32'hAB00_0000, 0, 1);         // LBU
      run_op(1'b1, 3'b101, 32'h10, 32'd2, 32'h0, 32'h8001_5A5A, 0, 1);         // LHU
      run_op(1'b1, 3'b001, 32'h10, 32'd1, 32'h0, 32'h0, 0, 1);                 // LH misaligned
      run_op(1'b1, 3'b010, 32'h10, 32'd2, 32'h0, 32'h0, 0, 1);                 // LW misaligned
      run_op(1'b0, 3'b010, 32'h100, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h0, 3, 1); // SW, ready late
      run_op(1'b0, 3'b001, 32'h20, 32'd2, 32'h1234_CAFE, 32'h0, 0, 1);         // SH upper half
      run_op(1'b1, 3'b001, 32'h20, 32'd2, 32'h0, 32'h8F00_1111, 2, 3);         // LH slow
      run_op(1'b1, 3'b010, 32'hFFFF_FFF0, 32'h14, 32'h0, 32'h1234_5678, 1, 2); // LW wrap
      run_op(1'b1, 3'b011, 32'h40, 32'd0, 32'h0, 32'h0, 0, 1);                 // illegal load
      run_op(1'b0, 3'b100, 32'h40, 32'd0, 32'h77, 32'h0, 0, 1);                // illegal store
      run_op(1'b0, 3'b000, 32'h40, 32'd1, 32'h0000_0055, 32'h0, 0, 1);         // SB lane 1

      // Stray response while idle must not touch load_data
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_0000;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("stray_rsp_ld", load_data, last_ld);
      chk("stray_rsp_done", 32'(op_done), 32'(1'b0));

      // Reset while waiting for a load response
      @(negedge clk);
      op_valid = 1'b1; op_load = 1'b1; op_funct3 = 3'b010; op_base = 32'h40; op_offset = '0;
      @(negedge clk);
      op_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("wait_stall", 32'(stall), 32'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("midrst_stall", 32'(stall), 32'(1'b0));
      chk("midrst_op_done", 32'(op_done), 32'(1'b0));
      chk("midrst_load_data", load_data, 32'h0);
      chk("midrst_req_valid", 32'(mem_req_valid), 32'(1'b0));
      chk("midrst_req_addr", mem_req_addr, 32'h0);
      chk("midrst_req_we", 32'(mem_req_we), 32'(1'b0));
      chk("midrst_misalign", 32'(misalign_err), 32'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("late_rsp_ld", load_data, 32'h0);
         chk("late_rsp_done", 32'(op_done), 32'(1'b0));
      end
      last_ld = '0;

      run_op(1'b1, 3'b000, 32'h40, 32'd2, 32'h0, 32'h0077_0000, 0, 1);         // LB after reset

`ifdef LSU_TIMEOUT_EN
      // Load whose response never comes: watchdog completes it with bus_err
      @(negedge clk);
      op_valid = 1'b1; op_load = 1'b1; op_funct3 = 3'b010; op_base = 32'h80; op_offset = '0;
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("to_done", 32'(op_done), 32'(k == int'(TO)));
         chk("to_bus_err", 32'(bus_err), 32'(k == int'(TO)));
         if (k >= 2) chk("to_req_valid", 32'(mem_req_valid), 32'(1'b0));
         if (k == int'(TO)) chk("to_load_data", load_data, last_ld);
         if (op_done) op_valid = 1'b0;
         mem_req_ready = (k == 1);
      end
      mem_req_ready = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Initiator side of the data-memory interface in the five-stage pipeline's MEM stage.
- Takes one load/store per operation from the EX/MEM boundary and computes the effective address (base + offset).
- Issues a valid/ready word request to the data RAM, waits for the load response, then lane-aligns and sign/zero-extends the load data.
- Stalls the pipeline while a memory operation is in flight.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width; fixed at 32 (4 byte lanes)
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  memory op present from EX/MEM
op_load  in  1  1 = load, 0 = store
op_funct3  in  3  size/sign field, RV32I encoding
op_base  in  32  rs1 value
op_offset  in  32  sign-extended immediate
op_wdata  in  32  rs2 value (store data)
stall  out  1  hold pipeline
op_done  out  1  one-cycle completion pulse
load_data  out  32  extended load result
misalign_err  out  1  valid with op_done
bus_err  out  1  valid with op_done
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write
mem_req_addr  out  32  word-aligned address
mem_req_wdata  out  32  lane-shifted store data
mem_req_wstrb  out  4  byte enables
mem_rsp_valid  in  1  read data valid
mem_rsp_rdata  in  32  read word

Behaviour:
- Reset: async on rst_n low; state IDLE; all outputs 0, including load_data.
- Effective address: ea = op_base + op_offset, mod 2^32 (wrap, no overflow flag).
- mem_req_addr = {ea[31:2], 2'b00}.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is treated as an error: misalign_err=1, no request issued.
- Misaligned access (half with ea[0]=1, word with ea[1:0]!=0): no request issued; op_done and misalign_err pulse 1 cycle after accept.
- Stores: wdata is replicated/shifted into lane ea[1:0].
  - wstrb SB = 0001<<ea[1:0]; SH = 0011<<ea[1:0]; SW = 1111.
- Request fields are captured at accept.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
  - IDLE: if op_valid, capture op; go to DONE on error, else to REQ.
  - REQ: mem_req_valid=1, all request fields held stable until mem_req_ready. On handshake, a store goes to DONE and a load goes to WAIT_RSP.
  - WAIT_RSP: on mem_rsp_valid, register the extended data into load_data and go to DONE.
  - DONE: op_done=1 for one cycle, then IDLE.
- load_data holds its value until the next load completes.
- stall = (IDLE & op_valid) | REQ | WAIT_RSP; stall is low in DONE. The pipeline advances on op_done and must not present the same op again.
- mem_rsp_valid outside WAIT_RSP is ignored.
- Responses must arrive at least 1 cycle after the request handshake.
- Minimum latency with zero-wait memory:
  - load: accept T, handshake T+1, rsp T+2, op_done T+3;
  - store: op_done T+2.
- Back-to-back ops: a new op is accepted in the IDLE cycle following DONE.
- Reset mid-operation aborts immediately; a late response arriving after reset is dropped.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro defined: a cycle counter clears on accept and counts in REQ and WAIT_RSP.
  - On reaching TIMEOUT_CYCLES: drop mem_req_valid, go to DONE, op_done=1 with bus_err=1; load_data is unchanged.
- Without the macro: no counter; the block waits indefinitely; bus_err is tied 0.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW);
  - state enum (IDLE, REQ, WAIT_RSP, DONE);
  - lane/strobe widths.
- One combinational sub-module, lsu_lane_align: store lane shift/strobe generation and load lane select/extend. The FSM stays in the top.

Test Plan:
- SB, base 0x10, offset 3, wdata 0x000000AB, ready=1 → mem_req_addr 0x10, wstrb 1000, wdata[31:24]=0xAB, we=1; op_done at T+2.
- LB at ea 0x13, rsp 0xAB000000 → load_data 0xFFFFFFAB; LBU same access → 0x000000AB; LHU at ea 0x12, rsp 0x8001xxxx → 0x00008001.
- LH at ea 0x11, or LW at ea 0x12 → mem_req_valid never asserted; op_done and misalign_err at T+1; stall high in T only.
- SW with mem_req_ready low for 3 cycles → addr/wdata/wstrb/we stable across all REQ cycles; stall high throughout; op_done 1 cycle after handshake.
- Load, rst_n pulsed low during WAIT_RSP, then mem_rsp_valid arrives → all outputs 0, FSM IDLE, response ignored, load_data stays 0.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, load with no response → op_done and bus_err 8 cycles after accept; mem_req_valid low from then on.
